// File: rtl/box_hit_judge_if.sv
// ---------------------------------------------------------------------------
// box_hit_judge_if
//   Signal bundle between the target generator / player input side (master)
//   and the round judge (slave).
//
//   Handshake: box_valid and hit_valid are single-cycle pulses from the
//   master. A new target is taken only while ready is high. The master does
//   not wait on ready: a pulse that arrives while ready is low is dropped,
//   not held. result_valid is a single-cycle pulse from the judge that
//   qualifies result_hit. There is no back-pressure on results.
//
//   Ports (master view):
//     box_valid, box[2:0]     out  new target pulse and box id
//     hit_valid, hit_box[2:0] out  player strike pulse and struck box id
//     ready                   in   judge idle, target accepted
//     target[2:0]             in   latched target, 0 when no round is active
//     flash                   in   flash request for target
//     result_valid            in   round outcome pulse
//     result_hit              in   outcome: 1 = hit, 0 = miss or timeout
//     score[7:0]              in   saturating hit count
//     lives_left[1:0]         in   remaining lives
//     game_over               in   game finished
// ---------------------------------------------------------------------------
interface box_hit_judge_if;
    logic       box_valid;
    logic [2:0] box;
    logic       hit_valid;
    logic [2:0] hit_box;
    logic       ready;
    logic [2:0] target;
    logic       flash;
    logic       result_valid;
    logic       result_hit;
    logic [7:0] score;
    logic [1:0] lives_left;
    logic       game_over;

    modport master (
        output box_valid, box, hit_valid, hit_box,
        input  ready, target, flash, result_valid, result_hit,
               score, lives_left, game_over
    );

    modport slave (
        input  box_valid, box, hit_valid, hit_box,
        output ready, target, flash, result_valid, result_hit,
               score, lives_left, game_over
    );
endinterface

// File: rtl/box_hit_judge.sv
// ---------------------------------------------------------------------------
// box_hit_judge
//   Round judge for whack-a-box. Each accepted target arms a response window
//   of WINDOW_CYCLES clocks while flash is high. A strike or a timeout closes
//   the round with a one-cycle result pulse. The judge keeps a saturating
//   score and counts lives down to game over.
//
//   Ports:
//     CLOCK_50      in   system clock, rising edge
//     reset_signal  in   synchronous active-high reset
//     bus           slave side of box_hit_judge_if (targets, strikes, status)
//     state_dbg     out  current FSM state (0 IDLE, 1 ARMED, 2 RESULT, 3 OVER)
// ---------------------------------------------------------------------------
module box_hit_judge #(
    parameter int WINDOW_CYCLES = 50000000,
    parameter int LIVES         = 3
) (
    input  logic            CLOCK_50,
    input  logic            reset_signal,
    box_hit_judge_if.slave  bus,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RESULT = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    // The timer counts WINDOW_CYCLES-1 down to 0. That value always fits in
    // $clog2(WINDOW_CYCLES) bits.
    localparam int            TW         = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    state_t        state_q, state_d;
    logic [2:0]    target_q, target_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic          hit_q, hit_d;

    logic box_legal;
    assign box_legal = (bus.box >= 3'd2) && (bus.box <= 3'd5);

    always_ff @(posedge CLOCK_50) begin
        if (reset_signal) begin
            state_q  <= S_IDLE;
            target_q <= 3'd0;
            timer_q  <= '0;
            score_q  <= 8'd0;
            lives_q  <= LIVES_INIT;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            hit_q    <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        timer_d  = timer_q;
        score_d  = score_q;
        lives_d  = lives_q;
        hit_d    = hit_q;

        case (state_q)
            S_IDLE: begin
                if (bus.box_valid && box_legal) begin
                    target_d = bus.box;
                    timer_d  = TIMER_LOAD;
                    state_d  = S_ARMED;
                end
            end

            S_ARMED: begin
                // A strike takes priority over the timeout. A strike that lands
                // on the last window cycle is still judged as a strike.
                if (bus.hit_valid) begin
                    state_d = S_RESULT;
                    if (bus.hit_box == target_q) begin
                        hit_d   = 1'b1;
                        score_d = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                    end else begin
                        hit_d   = 1'b0;
                        lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    end
                end else if (timer_q == '0) begin
                    state_d = S_RESULT;
                    hit_d   = 1'b0;
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            S_RESULT: begin
                target_d = 3'd0;
                state_d  = (lives_q == 2'd0) ? S_OVER : S_IDLE;
            end

            S_OVER: begin
                // Terminal state. Only reset_signal leaves it.
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ready        = (state_q == S_IDLE);
    assign bus.flash        = (state_q == S_ARMED);
    assign bus.result_valid = (state_q == S_RESULT);
    assign bus.game_over    = (state_q == S_OVER);
    assign bus.target       = target_q;
    assign bus.result_hit   = hit_q;
    assign bus.score        = score_q;
    assign bus.lives_left   = lives_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_box_hit_judge.sv
// ---------------------------------------------------------------------------
// tb_box_hit_judge
//   Directed bench for box_hit_judge with WINDOW_CYCLES=8 and LIVES=3.
//   Each round pushes its expected {result_hit, score, lives_left} onto a
//   queue. The result monitor pops and compares on every result_valid pulse.
// ---------------------------------------------------------------------------
module tb_box_hit_judge;

    localparam int WINDOW = 8;
    localparam int NLIVES = 3;
    localparam int EW     = 11;

    logic       CLOCK_50;
    logic       reset_signal;
    logic [1:0] state_dbg;

    box_hit_judge_if bus ();

    box_hit_judge #(
        .WINDOW_CYCLES (WINDOW),
        .LIVES         (NLIVES)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_signal (reset_signal),
        .bus          (bus),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock ----------------
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- counters / scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    int m_score;
    int m_lives;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: samples on the falling edge, away from the active edge.
    always @(negedge CLOCK_50) begin
        if (bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_result: observed=%0h expected=none",
                       {bus.result_hit, bus.score, bus.lives_left});
            end else begin
                logic [EW-1:0] e;
                logic [EW-1:0] o;
                e = exp_q.pop_front();
                o = {bus.result_hit, bus.score, bus.lives_left};
                total++;
                assert (o === e) else begin
                    bad++;
                    $error("FAIL result: observed=%0h expected=%0h", o, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_signal = 1'b1;
        tick(1);
        reset_signal = 1'b0;
        m_score = 0;
        m_lives = NLIVES;
    endtask

    task automatic send_box(input logic [2:0] b);
        bus.box_valid = 1'b1;
        bus.box       = b;
        tick(1);
        bus.box_valid = 1'b0;
    endtask

    task automatic strike(input logic [2:0] hb);
        bus.hit_valid = 1'b1;
        bus.hit_box   = hb;
        tick(1);
        bus.hit_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"},  32'(bus.ready), 32'd1);
        check({tag, "_flash"},  32'(bus.flash), 32'd0);
        check({tag, "_target"}, 32'(bus.target), 32'd0);
        check({tag, "_state"},  32'(state_dbg), 32'd0);
    endtask

    // One round. When do_hit is set, the strike is sampled on the n-th ARMED
    // cycle. Otherwise the window runs out. With extra set, a strike and a
    // legal box are driven during the RESULT cycle, and both must be dropped.
    task automatic round(input string tag, input logic [2:0] b, input int n,
                         input bit do_hit, input logic [2:0] hb, input bit extra);
        int  cnt;
        bit  was_hit;
        was_hit = do_hit && (hb == b);
        if (was_hit) begin
            if (m_score < 255) m_score++;
        end else begin
            if (m_lives > 0) m_lives--;
        end
        exp_q.push_back({was_hit, 8'(m_score), 2'(m_lives)});

        send_box(b);
        check({tag, "_armed_target"}, 32'(bus.target), 32'(b));
        check({tag, "_armed_ready"},  32'(bus.ready), 32'd0);

        cnt = 0;
        if (do_hit) begin
            for (int i = 0; i < n; i++) begin
                if (bus.flash === 1'b1) cnt++;
                if (i == n - 1) begin
                    bus.hit_valid = 1'b1;
                    bus.hit_box   = hb;
                end
                tick(1);
            end
            bus.hit_valid = 1'b0;
            check({tag, "_flash_cycles"}, 32'(cnt), 32'(n));
        end else begin
            for (int g = 0; g < WINDOW + 4; g++) begin
                if (bus.flash !== 1'b1) break;
                cnt++;
                tick(1);
            end
            check({tag, "_flash_cycles"}, 32'(cnt), 32'(WINDOW));
        end

        check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd1);
        if (extra) begin
            bus.hit_valid = 1'b1;
            bus.hit_box   = b;
            bus.box_valid = 1'b1;
            bus.box       = 3'd3;
            tick(1);
            bus.hit_valid = 1'b0;
            bus.box_valid = 1'b0;
        end else begin
            tick(1);
        end

        check({tag, "_after_rv"},     32'(bus.result_valid), 32'd0);
        check({tag, "_after_target"}, 32'(bus.target), 32'd0);
        check({tag, "_after_ready"},  32'(bus.ready), 32'(m_lives != 0));
        check({tag, "_after_over"},   32'(bus.game_over), 32'(m_lives == 0));
        check({tag, "_after_score"},  32'(bus.score), 32'(m_score));
        check({tag, "_after_lives"},  32'(bus.lives_left), 32'(m_lives));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.box_valid = 1'b0;
        bus.box       = 3'd0;
        bus.hit_valid = 1'b0;
        bus.hit_box   = 3'd0;
        reset_signal  = 1'b1;
        tick(2);
        reset_signal  = 1'b0;
        m_score = 0;
        m_lives = NLIVES;

        // Reset state
        check_idle("reset");
        check("reset_rv",    32'(bus.result_valid), 32'd0);
        check("reset_over",  32'(bus.game_over), 32'd0);
        check("reset_score", 32'(bus.score), 32'd0);
        check("reset_lives", 32'(bus.lives_left), 32'(NLIVES));
        check("reset_hit",   32'(bus.result_hit), 32'd0);

        // 1: hit on box 3, strike on the 4th ARMED cycle
        round("t1", 3'd3, 4, 1'b1, 3'd3, 1'b0);
        check_idle("t1_idle");

        // 2: timeout on box 4; a box_valid in the RESULT cycle is dropped
        round("t2", 3'd4, 0, 1'b0, 3'd0, 1'b1);
        check_idle("t2_idle");

        // 3: wrong box, then a correct-looking strike in RESULT is ignored
        round("t3", 3'd5, 2, 1'b1, 3'd2, 1'b1);
        check_idle("t3_idle");

        // 4: strike on the final window cycle counts as a hit
        round("t4", 3'd2, WINDOW, 1'b1, 3'd2, 1'b0);

        // 5: three misses from full lives, then game over
        apply_reset();
        check_idle("t5_reset");
        round("t5a", 3'd2, 1, 1'b1, 3'd3, 1'b0);
        round("t5b", 3'd3, 2, 1'b1, 3'd4, 1'b0);
        round("t5c", 3'd4, 3, 1'b1, 3'd5, 1'b0);
        check("t5_state_over", 32'(state_dbg), 32'd3);
        send_box(3'd3);
        strike(3'd3);
        tick(2);
        check("t5_over_hold",  32'(bus.game_over), 32'd1);
        check("t5_over_ready", 32'(bus.ready), 32'd0);
        check("t5_over_flash", 32'(bus.flash), 32'd0);
        check("t5_over_score", 32'(bus.score), 32'd0);
        check("t5_over_lives", 32'(bus.lives_left), 32'd0);
        apply_reset();
        check_idle("t5_after_reset");
        check("t5_reset_score", 32'(bus.score), 32'd0);
        check("t5_reset_lives", 32'(bus.lives_left), 32'(NLIVES));
        check("t5_reset_over",  32'(bus.game_over), 32'd0);

        // 6: illegal boxes are ignored in IDLE
        send_box(3'd1);
        check_idle("t6_box1");
        send_box(3'd7);
        check_idle("t6_box7");
        send_box(3'd0);
        check_idle("t6_box0");

        // 6: score saturates at 255 over 256 quick hits
        for (int i = 0; i < 256; i++) begin
            logic [2:0] b;
            b = 3'($urandom_range(2, 5));
            round("t6_hit", b, 1, 1'b1, b, 1'b0);
        end
        check("t6_score_sat", 32'(bus.score), 32'd255);
        check("t6_lives_keep", 32'(bus.lives_left), 32'(NLIVES));

        // 6: reset in the middle of a window
        send_box(3'd5);
        tick(2);
        check("t6_mid_flash", 32'(bus.flash), 32'd1);
        apply_reset();
        check_idle("t6_mid_reset");
        check("t6_mid_score", 32'(bus.score), 32'd0);
        tick(WINDOW + 2);
        check("t6_no_late_result", 32'(bus.result_valid), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
